// File: rtl/burst_group_arbiter_pkg.sv
// Shared types for the burst group arbiter: FSM state and request type encoding.
package burst_group_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   typedef enum logic {
      R_READ  = 1'b0,
      R_WRITE = 1'b1
   } r_type;

endpackage

// File: rtl/burst_group_arbiter_rr_first_picker.sv
// Round-robin first-set picker: lowest set request at or after ptr_i, wrapping mod NUM_CH.
module rr_first_picker #(
   parameter  int unsigned NUM_CH = 16,
   localparam int unsigned CHW    = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CHW-1:0]    ptr_i,
   output logic              found_o,
   output logic [CHW-1:0]    idx_o
);

   logic [NUM_CH-1:0] rot;
   logic [CHW-1:0]    sel;
   logic [CHW-1:0]    off;

   // Rotate so ptr_i lands at bit 0, priority-encode lowest bit, rotate the index back
   always_comb begin
      rot = '0;
      sel = '0;
      off = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         sel    = CHW'(i) + ptr_i;
         rot[i] = req_i[sel];
      end
      found_o = |rot;
      for (int unsigned k = NUM_CH; k > 0; k--) begin
         if (rot[k-1]) off = CHW'(k - 1);
      end
      idx_o = ptr_i + off;
   end

endmodule

// File: rtl/burst_group_arbiter.sv
// Burst group arbiter: round-robin grant of one scheduler channel per group, then
// streams up to BURST_LEN same-row/same-type beats through a registered output stage.
module burst_group_arbiter
   import burst_group_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_CH    = 16,
   parameter  int unsigned IDX       = 6,
   parameter  int unsigned RA        = 16,
   parameter  int unsigned CA        = 10,
   parameter  int unsigned DQ        = 16,
   parameter  int unsigned BURST_LEN = 4,
   parameter  int unsigned MAX_HOLD  = 16,
   localparam int unsigned CHW       = $clog2(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     valid_i,
   input  logic [NUM_CH*DQ-1:0]  data_i,
   input  logic [NUM_CH*IDX-1:0] idx_i,
   input  logic [NUM_CH*RA-1:0]  row_i,
   input  logic [NUM_CH*CA-1:0]  col_i,
   input  logic [NUM_CH-1:0]     t_i,
   output logic [NUM_CH-1:0]     ready_o,
   input  logic                  burst_open_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DQ-1:0]         data_o,
   output logic [IDX-1:0]        idx_o,
   output logic [RA-1:0]         row_o,
   output logic [CA-1:0]         col_o,
   output logic                  t_o,
   output logic [1:0]            ba_o,
   output logic [CHW-3:0]        bg_o,
   output logic                  last_o,
   output logic                  close_o
);

   localparam int unsigned BCW = $clog2(BURST_LEN + 1);
   localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   arb_state_t       state_q, state_d;
   logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CHW-1:0]   grant_ch_q, grant_ch_d;
   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [RA-1:0]    lock_row_q, lock_row_d;
   r_type            lock_t_q, lock_t_d;
   logic             out_valid_q, out_valid_d;
   logic [DQ-1:0]    data_q, data_d;
   logic [IDX-1:0]   idx_q, idx_d;
   logic [RA-1:0]    row_q, row_d;
   logic [CA-1:0]    col_q, col_d;
   logic             t_q, t_d;
   logic [1:0]       ba_q, ba_d;
   logic [CHW-3:0]   bg_q, bg_d;
   logic             last_q, last_d;

   logic             pick_found;
   logic [CHW-1:0]   pick_idx;
   logic             g_valid;
   logic [RA-1:0]    g_row;
   r_type            g_t;
   logic             locked;
   logic             space;
   logic             row_match;
   logic             accept;
   logic             beat_last;
   logic             close;

   rr_first_picker #(
      .NUM_CH (NUM_CH)
   ) u_picker (
      .req_i   (valid_i),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Same-cycle handshake with the granted channel and group-close decision
   always_comb begin
      g_valid   = valid_i[grant_ch_q];
      g_row     = row_i[grant_ch_q*RA +: RA];
      g_t       = r_type'(t_i[grant_ch_q]);
      locked    = (state_q == ARB_LOCKED) & ~rst;
      space     = ~out_valid_q | out_ready_i;
      row_match = g_valid & (g_row == lock_row_q) & (g_t == lock_t_q);
      accept    = locked & space & row_match;
      beat_last = (beat_cnt_q == BEAT_LAST);
      close     = locked & ((accept & beat_last)
                          | (g_valid & ~row_match)
                          | (~g_valid & (beat_cnt_q != '0))
                          | (hold_cnt_q == HOLD_LAST));
      ready_o             = '0;
      ready_o[grant_ch_q] = accept;
   end

   // Next-state for the grant FSM, counters and the output beat register
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_ch_d  = grant_ch_q;
      beat_cnt_d  = beat_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      lock_row_d  = lock_row_q;
      lock_t_d    = lock_t_q;
      out_valid_d = out_valid_q;
      data_d      = data_q;
      idx_d       = idx_q;
      row_d       = row_q;
      col_d       = col_q;
      t_d         = t_q;
      ba_d        = ba_q;
      bg_d        = bg_q;
      last_d      = last_q;

      case (state_q)
         ARB_IDLE: begin
            if (burst_open_i & pick_found) begin
               grant_ch_d = pick_idx;
               lock_row_d = row_i[pick_idx*RA +: RA];
               lock_t_d   = r_type'(t_i[pick_idx]);
               rr_ptr_d   = pick_idx + CHW'(1);
               beat_cnt_d = '0;
               hold_cnt_d = '0;
               state_d    = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
            if (close)  state_d    = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase

      // Payload is only overwritten on accept so it stays stable while stalled or idle
      if (accept) begin
         out_valid_d = 1'b1;
         data_d      = data_i[grant_ch_q*DQ +: DQ];
         idx_d       = idx_i[grant_ch_q*IDX +: IDX];
         row_d       = g_row;
         col_d       = col_i[grant_ch_q*CA +: CA];
         t_d         = t_i[grant_ch_q];
         ba_d        = grant_ch_q[1:0];
         bg_d        = grant_ch_q[CHW-1:2];
         last_d      = beat_last;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         grant_ch_q  <= '0;
         beat_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         lock_row_q  <= '0;
         lock_t_q    <= R_READ;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         idx_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         t_q         <= 1'b0;
         ba_q        <= '0;
         bg_q        <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_ch_q  <= grant_ch_d;
         beat_cnt_q  <= beat_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         lock_row_q  <= lock_row_d;
         lock_t_q    <= lock_t_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         idx_q       <= idx_d;
         row_q       <= row_d;
         col_q       <= col_d;
         t_q         <= t_d;
         ba_q        <= ba_d;
         bg_q        <= bg_d;
         last_q      <= last_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign data_o      = data_q;
   assign idx_o       = idx_q;
   assign row_o       = row_q;
   assign col_o       = col_q;
   assign t_o         = t_q;
   assign ba_o        = ba_q;
   assign bg_o        = bg_q;
   assign last_o      = last_q;
   assign close_o     = close;

endmodule

// File: tb/tb_burst_group_arbiter.sv
// Self-checking bench: per-channel request queues drive the arbiter; a queue-based
// reference model predicts ready/close each cycle and the exact outgoing beat stream.
module tb_burst_group_arbiter;

   localparam int unsigned NUM_CH    = 16;
   localparam int unsigned IDX       = 6;
   localparam int unsigned RA        = 16;
   localparam int unsigned CA        = 10;
   localparam int unsigned DQ        = 16;
   localparam int unsigned BURST_LEN = 4;
   localparam int unsigned MAX_HOLD  = 16;
   localparam int unsigned CHW       = 4;

   typedef struct packed {
      logic [DQ-1:0]  data;
      logic [IDX-1:0] idx;
      logic [RA-1:0]  row;
      logic [CA-1:0]  col;
      logic           t;
   } req_t;

   typedef struct packed {
      req_t           r;
      logic [1:0]     ba;
      logic [CHW-3:0] bg;
      logic           last;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_CH-1:0]     valid_i;
   logic [NUM_CH*DQ-1:0]  data_i;
   logic [NUM_CH*IDX-1:0] idx_i;
   logic [NUM_CH*RA-1:0]  row_i;
   logic [NUM_CH*CA-1:0]  col_i;
   logic [NUM_CH-1:0]     t_i;
   logic [NUM_CH-1:0]     ready_o;
   logic                  burst_open_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DQ-1:0]         data_o;
   logic [IDX-1:0]        idx_o;
   logic [RA-1:0]         row_o;
   logic [CA-1:0]         col_o;
   logic                  t_o;
   logic [1:0]            ba_o;
   logic [CHW-3:0]        bg_o;
   logic                  last_o;
   logic                  close_o;

   burst_group_arbiter #(
      .NUM_CH    (NUM_CH),
      .IDX       (IDX),
      .RA        (RA),
      .CA        (CA),
      .DQ        (DQ),
      .BURST_LEN (BURST_LEN),
      .MAX_HOLD  (MAX_HOLD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .data_i       (data_i),
      .idx_i        (idx_i),
      .row_i        (row_i),
      .col_i        (col_i),
      .t_i          (t_i),
      .ready_o      (ready_o),
      .burst_open_i (burst_open_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .data_o       (data_o),
      .idx_o        (idx_o),
      .row_o        (row_o),
      .col_o        (col_o),
      .t_o          (t_o),
      .ba_o         (ba_o),
      .bg_o         (bg_o),
      .last_o       (last_o),
      .close_o      (close_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // upstream request queues and stimulus knobs
   req_t        chq [NUM_CH][$];
   logic [RA-1:0] cur_row [NUM_CH];
   logic        cur_t   [NUM_CH];
   int unsigned gate_pct = 0;

   // reference model state
   beat_t       exp_out [$];
   bit          m_locked = 1'b0;
   int unsigned m_grant  = 0;
   int unsigned m_rr     = 0;
   int unsigned m_beats  = 0;
   int unsigned m_cyc    = 0;
   logic [RA-1:0] m_row  = '0;
   logic        m_t      = 1'b0;

   // observations of the DUT used for phase-level checks
   logic [NUM_CH-1:0] last_ready;
   int n_close       = 0;
   int n_close_stall = 0;
   int n_last        = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_req(input int unsigned c, input logic [RA-1:0] row, input logic t);
      req_t r;
      r.data = DQ'($urandom);
      r.idx  = IDX'($urandom);
      r.row  = row;
      r.col  = CA'($urandom);
      r.t    = t;
      chq[c].push_back(r);
   endtask

   task automatic fill_random(input int unsigned c, input int unsigned n);
      logic [RA-1:0] rows3 [3];
      rows3[0] = 16'h0010;
      rows3[1] = 16'h0022;
      rows3[2] = 16'h0031;
      for (int unsigned i = 0; i < n; i++) begin
         if ($urandom_range(99) < 25) cur_row[c] = rows3[$urandom_range(2)];
         if ($urandom_range(99) < 10) cur_t[c] = ~cur_t[c];
         push_req(c, cur_row[c], cur_t[c]);
      end
   endtask

   function automatic int unsigned pending();
      int unsigned s = 0;
      for (int unsigned c = 0; c < NUM_CH; c++) s += chq[c].size();
      return s;
   endfunction

   task automatic drive_inputs();
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         req_t r;
         r = '0;
         if (chq[c].size() > 0) r = chq[c][0];
         valid_i[c]             = (chq[c].size() > 0) && ($urandom_range(99) >= gate_pct);
         data_i[c*DQ +: DQ]     = r.data;
         idx_i[c*IDX +: IDX]    = r.idx;
         row_i[c*RA +: RA]      = r.row;
         col_i[c*CA +: CA]      = r.col;
         t_i[c]                 = r.t;
      end
   endtask

   // Predict this cycle from the group rules, compare, then advance the model
   task automatic model_cycle();
      logic [NUM_CH-1:0] exp_ready;
      logic  exp_close, acc, v, match, space;
      req_t  cur;
      beat_t b;
      int unsigned g;
      exp_ready = '0;
      exp_close = 1'b0;
      acc       = 1'b0;
      cur       = '0;
      last_ready = ready_o;
      if (close_o === 1'b1) begin
         n_close++;
         if (!out_ready_i) n_close_stall++;
      end
      if (out_valid_o === 1'b1 && out_ready_i && last_o === 1'b1) n_last++;

      check_eq("out_valid", out_valid_o, exp_out.size() > 0);
      if (exp_out.size() > 0) begin
         b = exp_out[0];
         check_eq("data", data_o, b.r.data);
         check_eq("idx",  idx_o,  b.r.idx);
         check_eq("row",  row_o,  b.r.row);
         check_eq("col",  col_o,  b.r.col);
         check_eq("t",    t_o,    b.r.t);
         check_eq("ba",   ba_o,   b.ba);
         check_eq("bg",   bg_o,   b.bg);
         check_eq("last", last_o, b.last);
      end

      if (rst) begin
         check_eq("rst_ready", ready_o, 0);
         check_eq("rst_close", close_o, 0);
         exp_out.delete();
         m_locked = 1'b0;
         m_rr     = 0;
         return;
      end

      if (m_locked) begin
         g = m_grant;
         v = valid_i[g];
         if (v) cur = chq[g][0];
         space = (exp_out.size() == 0) || out_ready_i;
         match = v && (cur.row == m_row) && (cur.t == m_t);
         acc   = space && match;
         exp_ready[g] = acc;
         exp_close = (acc && (m_beats == BURST_LEN - 1)) || (v && !match)
                   || (!v && (m_beats > 0)) || (m_cyc == MAX_HOLD - 1);
      end
      check_eq("ready", ready_o, exp_ready);
      check_eq("close", close_o, exp_close);

      if (exp_out.size() > 0 && out_ready_i) void'(exp_out.pop_front());
      if (acc) begin
         b.r    = cur;
         b.ba   = 2'(m_grant % 4);
         b.bg   = (CHW-2)'(m_grant / 4);
         b.last = (m_beats == BURST_LEN - 1);
         exp_out.push_back(b);
         void'(chq[m_grant].pop_front());
      end

      if (m_locked) begin
         m_cyc++;
         if (acc) m_beats++;
         if (exp_close) m_locked = 1'b0;
      end else if (burst_open_i && (valid_i != '0)) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (valid_i[(m_rr + k) % NUM_CH]) begin
               m_grant = (m_rr + k) % NUM_CH;
               break;
            end
         end
         m_row    = chq[m_grant][0].row;
         m_t      = chq[m_grant][0].t;
         m_rr     = (m_grant + 1) % NUM_CH;
         m_beats  = 0;
         m_cyc    = 0;
         m_locked = 1'b1;
      end
   endtask

   task automatic step();
      drive_inputs();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      int cyc = 0;
      while ((pending() != 0 || exp_out.size() != 0 || m_locked) && cyc < budget) begin
         step();
         cyc++;
      end
      check_eq(tag, pending() + exp_out.size(), 0);
   endtask

   task automatic clear_counts();
      n_close       = 0;
      n_close_stall = 0;
      n_last        = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         cur_row[c] = 16'h0010;
         cur_t[c]   = 1'b0;
      end
      rst          = 1'b1;
      burst_open_i = 1'b1;
      out_ready_i  = 1'b1;

      // reset with every channel requesting
      for (int unsigned c = 0; c < NUM_CH; c++) push_req(c, 16'h0010, 1'b0);
      drive_inputs();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_eq("reset_ready",     ready_o,     0);
      check_eq("reset_out_valid", out_valid_o, 0);
      check_eq("reset_close",     close_o,     0);
      check_eq("reset_payload", {data_o, idx_o, row_o, col_o, t_o, ba_o, bg_o, last_o}, 0);
      for (int unsigned c = 0; c < NUM_CH; c++) chq[c].delete();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // round-robin over channels 3, 7, 12 with a shared row
      clear_counts();
      for (int unsigned i = 0; i < 8; i++) begin
         push_req(3, 16'h0040, 1'b0);
         push_req(7, 16'h0040, 1'b0);
         push_req(12, 16'h0040, 1'b0);
      end
      drain("rr_drain", 300);
      check_eq("rr_closes", n_close, 6);
      check_eq("rr_last_beats", n_last, 6);

      // row change inside channel 5 splits it into two groups
      clear_counts();
      push_req(5, 16'h0010, 1'b1);
      push_req(5, 16'h0010, 1'b1);
      push_req(5, 16'h0022, 1'b1);
      drain("rowbrk_drain", 100);
      check_eq("rowbrk_closes", n_close, 2);

      // output stall long enough for the hold timer to close the group
      clear_counts();
      for (int unsigned i = 0; i < 12; i++) push_req(9, 16'h0070, 1'b0);
      step();
      step();
      out_ready_i = 1'b0;
      for (int unsigned i = 0; i < 20; i++) step();
      out_ready_i = 1'b1;
      drain("stall_drain", 300);
      check_eq("hold_expiry_close", n_close_stall != 0, 1);

      // burst_open_i gating, then first grant from a freshly reset pointer
      rst = 1'b1;
      step();
      rst = 1'b0;
      burst_open_i = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         push_req(c, 16'h0011, 1'b0);
         push_req(c, 16'h0011, 1'b0);
      end
      for (int unsigned i = 0; i < 10; i++) step();
      burst_open_i = 1'b1;
      step();
      step();
      check_eq("gate_first_grant", last_ready, 16'h0001);
      drain("gate_drain", 600);

      // reset while a beat sits in the output register
      out_ready_i = 1'b0;
      push_req(2, 16'h0055, 1'b1);
      push_req(2, 16'h0055, 1'b1);
      for (int unsigned i = 0; i < 10 && exp_out.size() == 0; i++) step();
      check_eq("midrst_pending", out_valid_o, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready_i = 1'b1;
      step();
      check_eq("midrst_dropped", out_valid_o, 0);
      step();
      check_eq("midrst_regrant", last_ready, 16'h0004);
      drain("midrst_drain", 100);

      // randomized traffic with gaps, backpressure, gating and occasional reset
      for (int unsigned n = 0; n < 1500; n++) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (chq[c].size() < 2 && $urandom_range(7) == 0) fill_random(c, $urandom_range(6, 1));
         end
         gate_pct     = 10;
         out_ready_i  = ($urandom_range(99) < 70);
         burst_open_i = ($urandom_range(99) < 80);
         rst          = ($urandom_range(299) == 0);
         step();
      end
      rst          = 1'b0;
      gate_pct     = 0;
      out_ready_i  = 1'b1;
      burst_open_i = 1'b1;
      drain("random_drain", 3000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
